// File: rtl/dmem_pkg.sv
// Shared encodings and lane/extension helpers for the data-memory responder.
package dmem_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_ILL  = 2'b11
    } size_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_RESP
    } state_e;

    // Byte-lane write enables; anything that is not byte/half is a full word.
    function automatic logic [3:0] lane_en(input logic [1:0] size, input logic [1:0] lo);
        case (size)
            SZ_BYTE: lane_en = 4'b0001 << lo;
            SZ_HALF: lane_en = lo[1] ? 4'b1100 : 4'b0011;
            default: lane_en = 4'b1111;
        endcase
    endfunction

    // Replicate LSB-aligned store data onto every lane so the enables pick the target.
    function automatic logic [31:0] wdata_lanes(input logic [1:0] size, input logic [31:0] wdata);
        case (size)
            SZ_BYTE: wdata_lanes = {4{wdata[7:0]}};
            SZ_HALF: wdata_lanes = {2{wdata[15:0]}};
            default: wdata_lanes = wdata;
        endcase
    endfunction

    function automatic logic [31:0] load_extend(input logic [31:0] word, input logic [1:0] size,
                                                input logic [1:0] lo, input logic uns);
        logic [7:0]  b;
        logic [15:0] h;
        b = word[{lo, 3'b000} +: 8];
        h = lo[1] ? word[31:16] : word[15:0];
        case (size)
            SZ_BYTE: load_extend = uns ? {24'b0, b} : {{24{b[7]}}, b};
            SZ_HALF: load_extend = uns ? {16'b0, h} : {{16{h[15]}}, h};
            default: load_extend = word;
        endcase
    endfunction

endpackage

// File: rtl/dmem_if.sv
// Load/store request/response bundle between the core (master) and the responder (slave).
interface dmem_if;
    logic        req_valid;
    logic        req_wrt;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic        req_ready;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    modport master (
        output req_valid, req_wrt, req_addr, req_wdata, req_size, req_unsigned,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_wrt, req_addr, req_wdata, req_size, req_unsigned,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/dmem_array.sv
// DEPTH_WORDS x 32 storage: synchronous byte-enabled write, asynchronous read at the same index.
module dmem_array #(
    parameter int DEPTH_WORDS = 256,
    localparam int AW = $clog2(DEPTH_WORDS)
) (
    input  logic          clk,
    input  logic [3:0]    we,
    input  logic [AW-1:0] idx,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    logic [31:0] mem [DEPTH_WORDS];

    // NOTE: storage has no reset branch; resetting an array forces it into flops instead of RAM.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (we[i]) mem[idx][8*i +: 8] <= wdata[8*i +: 8];
        end
    end

    assign rdata = mem[idx];

endmodule

// File: rtl/dmem_responder.sv
// Valid/ready data-memory responder with WAIT_CYCLES wait states.
// Define DMEM_ERR_EN to reject misaligned, out-of-range and size-11 requests.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int WAIT_CYCLES = 1
) (
    input  logic   clk,
    input  logic   rst,
    dmem_if.slave  bus
);

    localparam int         AW        = $clog2(DEPTH_WORDS);
    localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

    state_e      state;
    logic [3:0]  cnt;
    logic        ready_q;
    logic        rsp_valid_q;
    logic        rsp_err_q;
    logic [31:0] rsp_rdata_q;

    logic        cap_wrt;
    logic        cap_uns;
    logic [1:0]  cap_size;
    logic [31:0] cap_addr;
    logic [31:0] cap_wdata;

    logic        in_idle;
    logic        accept;
    logic        access;
    logic        illegal;
    logic        acc_wrt;
    logic        acc_uns;
    logic [1:0]  acc_size;
    logic [31:0] acc_addr;
    logic [31:0] acc_wdata;
    logic [3:0]  mem_we;
    logic [31:0] mem_rdata;
    logic [31:0] load_data;

    assign in_idle = (state == ST_IDLE);
    assign accept  = in_idle && bus.req_valid && ready_q;

    // A zero-wait access happens at the accept edge, so it must see the live request.
    assign acc_wrt   = in_idle ? bus.req_wrt      : cap_wrt;
    assign acc_uns   = in_idle ? bus.req_unsigned : cap_uns;
    assign acc_size  = in_idle ? bus.req_size     : cap_size;
    assign acc_addr  = in_idle ? bus.req_addr     : cap_addr;
    assign acc_wdata = in_idle ? bus.req_wdata    : cap_wdata;

    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    always_comb begin
        illegal = 1'b0;
`ifdef DMEM_ERR_EN
        illegal = (acc_size == SZ_ILL)
               || ((acc_size == SZ_HALF) && acc_addr[0])
               || ((acc_size == SZ_WORD) && (acc_addr[1:0] != 2'b00))
               || (acc_addr[31:2] >= 30'(DEPTH_WORDS));
`endif
    end

    assign access = !illegal && ((accept && (WAIT_CYCLES == 0))
                              || ((state == ST_WAIT) && (cnt == 4'd1)));

    // Reset wins at the access edge too: the write is dropped.
    assign mem_we    = (access && acc_wrt && !rst) ? lane_en(acc_size, acc_addr[1:0]) : 4'b0000;
    assign load_data = acc_wrt ? 32'b0 : load_extend(mem_rdata, acc_size, acc_addr[1:0], acc_uns);

    dmem_array #(.DEPTH_WORDS(DEPTH_WORDS)) u_array (
        .clk   (clk),
        .we    (mem_we),
        .idx   (acc_addr[AW+1:2]),
        .wdata (wdata_lanes(acc_size, acc_wdata)),
        .rdata (mem_rdata)
    );

    always_ff @(posedge clk) begin
        if (accept) begin
            cap_wrt   <= bus.req_wrt;
            cap_uns   <= bus.req_unsigned;
            cap_size  <= bus.req_size;
            cap_addr  <= bus.req_addr;
            cap_wdata <= bus.req_wdata;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            cnt         <= 4'd0;
            ready_q     <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= 32'b0;
        end else begin
            rsp_valid_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        ready_q <= 1'b0;
                        if (illegal) begin
                            state       <= ST_RESP;
                            rsp_valid_q <= 1'b1;
                            rsp_err_q   <= 1'b1;
                            rsp_rdata_q <= 32'b0;
                        end else if (WAIT_CYCLES == 0) begin
                            state       <= ST_RESP;
                            rsp_valid_q <= 1'b1;
                            rsp_err_q   <= 1'b0;
                            rsp_rdata_q <= load_data;
                        end else begin
                            cnt   <= WAIT_INIT;
                            state <= ST_WAIT;
                        end
                    end else begin
                        ready_q <= 1'b1;
                    end
                end
                ST_WAIT: begin
                    cnt <= cnt - 4'd1;
                    if (cnt == 4'd1) begin
                        state       <= ST_RESP;
                        rsp_valid_q <= 1'b1;
                        rsp_err_q   <= 1'b0;
                        rsp_rdata_q <= load_data;
                    end
                end
                ST_RESP: begin
                    state   <= ST_IDLE;
                    ready_q <= 1'b1;
                end
                default: begin
                    state   <= ST_IDLE;
                    ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign bus.req_ready = ready_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: three instances with WAIT_CYCLES 0, 1 and 3 share one request bus.
module tb_dmem_responder;

    localparam int DEPTH = 256;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    logic        t_wrt = 1'b0;
    logic [31:0] t_addr = '0;
    logic [31:0] t_wdata = '0;
    logic [1:0]  t_size = '0;
    logic        t_uns = 1'b0;
    logic [2:0]  t_valid = '0;

    dmem_if bus0 ();
    dmem_if bus1 ();
    dmem_if bus3 ();

    assign bus0.req_valid = t_valid[0];
    assign bus1.req_valid = t_valid[1];
    assign bus3.req_valid = t_valid[2];
    assign bus0.req_wrt = t_wrt;   assign bus1.req_wrt = t_wrt;   assign bus3.req_wrt = t_wrt;
    assign bus0.req_addr = t_addr; assign bus1.req_addr = t_addr; assign bus3.req_addr = t_addr;
    assign bus0.req_wdata = t_wdata; assign bus1.req_wdata = t_wdata; assign bus3.req_wdata = t_wdata;
    assign bus0.req_size = t_size; assign bus1.req_size = t_size; assign bus3.req_size = t_size;
    assign bus0.req_unsigned = t_uns; assign bus1.req_unsigned = t_uns; assign bus3.req_unsigned = t_uns;

    logic [2:0]  rdy;
    logic [2:0]  vld;
    logic [2:0]  errs;
    logic [31:0] rdat [3];
    assign rdy  = {bus3.req_ready, bus1.req_ready, bus0.req_ready};
    assign vld  = {bus3.rsp_valid, bus1.rsp_valid, bus0.rsp_valid};
    assign errs = {bus3.rsp_err, bus1.rsp_err, bus0.rsp_err};
    assign rdat[0] = bus0.rsp_rdata;
    assign rdat[1] = bus1.rsp_rdata;
    assign rdat[2] = bus3.rsp_rdata;

    dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(0)) u_w0 (.clk(clk), .rst(rst), .bus(bus0));
    dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(1)) u_w1 (.clk(clk), .rst(rst), .bus(bus1));
    dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(3)) u_w3 (.clk(clk), .rst(rst), .bus(bus3));

    // One request on instance sel; lat counts edges from the accept edge (inclusive) to rsp_valid.
    task automatic xact(input int sel, input logic wrt, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [1:0] size, input logic uns,
                        output logic [31:0] rdata, output logic err, output int lat, output logic drop);
        int n;
        @(negedge clk);
        t_wrt = wrt; t_addr = addr; t_wdata = wdata; t_size = size; t_uns = uns;
        t_valid[sel] = 1'b1;
        n = 0;
        while (!rdy[sel] && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) begin
            total++; bad++;
            $display("FAIL ready_timeout sel=%0d addr=%h", sel, addr);
        end
        @(posedge clk);
        #1 t_valid[sel] = 1'b0;
        lat = 1;
        while (!vld[sel] && lat < 40) begin
            @(posedge clk);
            #1 lat++;
        end
        if (lat >= 40) begin
            total++; bad++;
            $display("FAIL rsp_timeout sel=%0d addr=%h", sel, addr);
        end
        rdata = rdat[sel];
        err   = errs[sel];
        @(posedge clk);
        #1 drop = vld[sel];
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        total++; if (rdy !== 3'b000) begin bad++; $display("FAIL rst_ready got=%b want=000", rdy); end
        total++; if (vld !== 3'b000) begin bad++; $display("FAIL rst_valid got=%b want=000", vld); end
        total++; if (errs !== 3'b000) begin bad++; $display("FAIL rst_err got=%b want=000", errs); end
        total++; if (rdat[1] !== 32'h0) begin bad++; $display("FAIL rst_rdata got=%h want=0", rdat[1]); end
        @(negedge clk);
        rst = 1'b0;
        total++; if (rdy !== 3'b000) begin bad++; $display("FAIL rst_drop_ready got=%b want=000", rdy); end
        @(posedge clk);
        #1;
        total++; if (rdy !== 3'b111) begin bad++; $display("FAIL post_rst_ready got=%b want=111", rdy); end
    endtask

    task automatic test_word;
        logic [31:0] rd; logic er; int lt; logic dr;
        xact(1, 1'b1, 32'h10, 32'hDEADBEEF, 2'b10, 1'b0, rd, er, lt, dr);
        total++; if (rd !== 32'h0 || er !== 1'b0) begin bad++; $display("FAIL store_word_rsp got=%h/%b want=0/0", rd, er); end
        total++; if (lt !== 2) begin bad++; $display("FAIL store_word_lat got=%0d want=2", lt); end
        xact(1, 1'b0, 32'h10, 32'h0, 2'b10, 1'b0, rd, er, lt, dr);
        total++; if (rd !== 32'hDEADBEEF) begin bad++; $display("FAIL load_word got=%h want=deadbeef", rd); end
        total++; if (er !== 1'b0) begin bad++; $display("FAIL load_word_err got=%b want=0", er); end
        total++; if (lt !== 2) begin bad++; $display("FAIL load_word_lat got=%0d want=2", lt); end
        total++; if (dr !== 1'b0) begin bad++; $display("FAIL valid_one_cycle got=%b want=0", dr); end
        total++; if (rdat[1] !== 32'hDEADBEEF) begin bad++; $display("FAIL rdata_hold got=%h want=deadbeef", rdat[1]); end
    endtask

    task automatic test_byte;
        logic [31:0] rd; logic er; int lt; logic dr;
        xact(1, 1'b1, 32'h13, 32'hAAAAAA80, 2'b00, 1'b0, rd, er, lt, dr);
        xact(1, 1'b0, 32'h13, 32'h0, 2'b00, 1'b0, rd, er, lt, dr);
        total++; if (rd !== 32'hFFFFFF80) begin bad++; $display("FAIL load_sbyte got=%h want=ffffff80", rd); end
        xact(1, 1'b0, 32'h13, 32'h0, 2'b00, 1'b1, rd, er, lt, dr);
        total++; if (rd !== 32'h00000080) begin bad++; $display("FAIL load_ubyte got=%h want=00000080", rd); end
        xact(1, 1'b0, 32'h10, 32'h0, 2'b10, 1'b0, rd, er, lt, dr);
        total++; if (rd !== 32'h80ADBEEF) begin bad++; $display("FAIL word_after_byte got=%h want=80adbeef", rd); end
    endtask

    task automatic test_half;
        logic [31:0] rd; logic er; int lt; logic dr;
        xact(1, 1'b1, 32'h12, 32'h55551234, 2'b01, 1'b0, rd, er, lt, dr);
        xact(1, 1'b0, 32'h12, 32'h0, 2'b01, 1'b1, rd, er, lt, dr);
        total++; if (rd !== 32'h00001234) begin bad++; $display("FAIL load_uhalf got=%h want=00001234", rd); end
        xact(1, 1'b0, 32'h10, 32'h0, 2'b10, 1'b0, rd, er, lt, dr);
        total++; if (rd !== 32'h1234BEEF) begin bad++; $display("FAIL word_after_half got=%h want=1234beef", rd); end
        xact(1, 1'b0, 32'h10, 32'h0, 2'b01, 1'b0, rd, er, lt, dr);
        total++; if (rd !== 32'hFFFFBEEF) begin bad++; $display("FAIL load_shalf_lo got=%h want=ffffbeef", rd); end
        xact(1, 1'b0, 32'h11, 32'h0, 2'b00, 1'b1, rd, er, lt, dr);
        total++; if (rd !== 32'h000000BE) begin bad++; $display("FAIL load_ubyte_1 got=%h want=000000be", rd); end
    endtask

    task automatic test_zero_wait;
        logic [31:0] rd; logic er; int lt; logic dr;
        xact(0, 1'b1, 32'h10, 32'hDEADBEEF, 2'b10, 1'b0, rd, er, lt, dr);
        total++; if (lt !== 1) begin bad++; $display("FAIL w0_store_lat got=%0d want=1", lt); end
        xact(0, 1'b1, 32'h13, 32'h00000080, 2'b00, 1'b0, rd, er, lt, dr);
        xact(0, 1'b1, 32'h12, 32'h00001234, 2'b01, 1'b0, rd, er, lt, dr);
        xact(0, 1'b0, 32'h10, 32'h0, 2'b10, 1'b0, rd, er, lt, dr);
        total++; if (rd !== 32'h1234BEEF) begin bad++; $display("FAIL w0_load_word got=%h want=1234beef", rd); end
        total++; if (lt !== 1) begin bad++; $display("FAIL w0_load_lat got=%0d want=1", lt); end
        total++; if (dr !== 1'b0) begin bad++; $display("FAIL w0_valid_one_cycle got=%b want=0", dr); end
        xact(0, 1'b0, 32'h13, 32'h0, 2'b00, 1'b0, rd, er, lt, dr);
        total++; if (rd !== 32'h00000012) begin bad++; $display("FAIL w0_load_sbyte got=%h want=00000012", rd); end
    endtask

    task automatic test_illegal;
        logic [31:0] rd; logic er; int lt; logic dr;
        xact(1, 1'b0, 32'h11, 32'h0, 2'b10, 1'b0, rd, er, lt, dr);
`ifdef DMEM_ERR_EN
        total++; if (er !== 1'b1 || rd !== 32'h0) begin bad++; $display("FAIL ill_word_load got=%h/%b want=0/1", rd, er); end
        total++; if (lt !== 1) begin bad++; $display("FAIL ill_lat got=%0d want=1", lt); end
`else
        total++; if (er !== 1'b0 || rd !== 32'h1234BEEF) begin bad++; $display("FAIL ill_word_load got=%h/%b want=1234beef/0", rd, er); end
        total++; if (lt !== 2) begin bad++; $display("FAIL ill_lat got=%0d want=2", lt); end
`endif
        xact(1, 1'b0, 32'h10, 32'h0, 2'b11, 1'b0, rd, er, lt, dr);
`ifdef DMEM_ERR_EN
        total++; if (er !== 1'b1 || rd !== 32'h0) begin bad++; $display("FAIL size11_load got=%h/%b want=0/1", rd, er); end
`else
        total++; if (er !== 1'b0 || rd !== 32'h1234BEEF) begin bad++; $display("FAIL size11_load got=%h/%b want=1234beef/0", rd, er); end
`endif
        xact(1, 1'b0, 32'h11, 32'h0, 2'b01, 1'b1, rd, er, lt, dr);
`ifdef DMEM_ERR_EN
        total++; if (er !== 1'b1 || rd !== 32'h0) begin bad++; $display("FAIL ill_half_load got=%h/%b want=0/1", rd, er); end
`else
        total++; if (er !== 1'b0 || rd !== 32'h0000BEEF) begin bad++; $display("FAIL ill_half_load got=%h/%b want=0000beef/0", rd, er); end
`endif
        xact(1, 1'b1, 32'h10, 32'hFFFFFFFF, 2'b11, 1'b0, rd, er, lt, dr);
        xact(1, 1'b0, 32'h10, 32'h0, 2'b10, 1'b0, rd, er, lt, dr);
        total++; if (er !== 1'b0) begin bad++; $display("FAIL err_clears got=%b want=0", er); end
`ifdef DMEM_ERR_EN
        total++; if (rd !== 32'h1234BEEF) begin bad++; $display("FAIL ill_store_nowrite got=%h want=1234beef", rd); end
`else
        total++; if (rd !== 32'hFFFFFFFF) begin bad++; $display("FAIL size11_store got=%h want=ffffffff", rd); end
`endif
    endtask

    task automatic test_range;
        logic [31:0] rd; logic er; int lt; logic dr;
        xact(1, 1'b1, 32'h0, 32'hA5A5A5A5, 2'b10, 1'b0, rd, er, lt, dr);
        xact(1, 1'b1, 32'(4 * DEPTH), 32'h11223344, 2'b10, 1'b0, rd, er, lt, dr);
`ifdef DMEM_ERR_EN
        total++; if (er !== 1'b1) begin bad++; $display("FAIL range_err got=%b want=1", er); end
`else
        total++; if (er !== 1'b0) begin bad++; $display("FAIL range_err got=%b want=0", er); end
`endif
        xact(1, 1'b0, 32'h0, 32'h0, 2'b10, 1'b0, rd, er, lt, dr);
`ifdef DMEM_ERR_EN
        total++; if (rd !== 32'hA5A5A5A5) begin bad++; $display("FAIL range_word0 got=%h want=a5a5a5a5", rd); end
`else
        total++; if (rd !== 32'h11223344) begin bad++; $display("FAIL range_word0 got=%h want=11223344", rd); end
`endif
    endtask

    task automatic test_reset_in_wait;
        logic [31:0] rd; logic er; int lt; logic dr;
        logic seen;
        int n;
        xact(2, 1'b1, 32'h20, 32'h11111111, 2'b10, 1'b0, rd, er, lt, dr);
        total++; if (lt !== 4) begin bad++; $display("FAIL w3_lat got=%0d want=4", lt); end
        @(negedge clk);
        t_wrt = 1'b1; t_addr = 32'h20; t_wdata = 32'hCAFEF00D; t_size = 2'b10; t_uns = 1'b0;
        t_valid[2] = 1'b1;
        n = 0;
        while (!rdy[2] && n < 20) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        #1 t_valid[2] = 1'b0;
        seen = vld[2];
        repeat (2) begin
            @(posedge clk);
            #1 seen = seen | vld[2];
        end
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1 seen = seen | vld[2];
        @(negedge clk);
        rst = 1'b0;
        total++; if (rdy[2] !== 1'b0) begin bad++; $display("FAIL wait_rst_ready_low got=%b want=0", rdy[2]); end
        @(posedge clk);
        #1;
        total++; if (rdy[2] !== 1'b1) begin bad++; $display("FAIL wait_rst_ready_high got=%b want=1", rdy[2]); end
        repeat (4) begin
            @(posedge clk);
            #1 seen = seen | vld[2];
        end
        total++; if (seen !== 1'b0) begin bad++; $display("FAIL wait_rst_no_valid got=%b want=0", seen); end
        xact(2, 1'b0, 32'h20, 32'h0, 2'b10, 1'b0, rd, er, lt, dr);
        total++; if (rd !== 32'h11111111) begin bad++; $display("FAIL wait_rst_nowrite got=%h want=11111111", rd); end
    endtask

    task automatic test_back_to_back;
        int acc_t[3];
        int na;
        na = 0;
        @(negedge clk);
        t_wrt = 1'b0; t_addr = 32'h20; t_size = 2'b10; t_uns = 1'b0;
        t_valid[2] = 1'b1;
        for (int c = 0; c < 40 && na < 3; c++) begin
            if (rdy[2]) begin
                acc_t[na] = cyc;
                na++;
            end
            @(negedge clk);
        end
        t_valid[2] = 1'b0;
        repeat (8) @(posedge clk);
        total++;
        if (na !== 3) begin
            bad++; $display("FAIL b2b_accepts got=%0d want=3", na);
        end else begin
            total++; if (acc_t[1] - acc_t[0] !== 5) begin bad++; $display("FAIL b2b_gap0 got=%0d want=5", acc_t[1] - acc_t[0]); end
            total++; if (acc_t[2] - acc_t[1] !== 5) begin bad++; $display("FAIL b2b_gap1 got=%0d want=5", acc_t[2] - acc_t[1]); end
        end
        total++; if (rdat[2] !== 32'h11111111) begin bad++; $display("FAIL b2b_rdata got=%h want=11111111", rdat[2]); end
    endtask

    initial begin
        test_reset();
        test_word();
        test_byte();
        test_half();
        test_zero_wait();
        test_illegal();
        test_range();
        test_reset_in_wait();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
